// File: rtl/sram_sdp_be.sv
// sram_sdp_be: simple-dual-port synchronous SRAM, byte-lane write enables,
//   registered read port with valid strobe, hardware clear after reset.
// Latency: read result visible RD_LAT cycles after re is sampled; write
//   visible to the next read (same-edge collisions follow WRITE_FIRST).
// Backpressure: none while ready; while busy (clear in progress) every
//   request is silently dropped, so callers must wait for busy to fall.
//
// Ports:
//   clk            rising-edge clock for all state
//   rst            synchronous active-high reset; starts the clear sequence
//   we/waddr/wdata/wbe   write port; wbe[i] enables wdata[8i+7:8i]
//   re/raddr       read request and address
//   rdata/rvalid   read result and one-cycle valid strobe; rdata holds otherwise
//   busy           high while memory is being cleared
//
// Parameters: M data width (multiple of 8), N depth (>= 2, any value),
// RD_LAT 1 or 2, WRITE_FIRST 1 = new data on collision, 0 = old data.

module sram_sdp_be #(
  parameter int M           = 8,
  parameter int N           = 1024,
  parameter int RD_LAT      = 1,
  parameter int WRITE_FIRST = 1,
  parameter int AW          = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [M-1:0]    wdata,
  input  logic [M/8-1:0]  wbe,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [M-1:0]    rdata,
  output logic            rvalid,
  output logic            busy
);

  localparam int NB = M / 8;

  // One extra bit so the depth itself is representable when N = 2**AW.
  localparam logic [AW:0]   DEPTH = (AW + 1)'(N);
  localparam logic [AW-1:0] LAST  = AW'(N - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;

  logic [M-1:0] mem [N];

  logic          waddr_ok;
  logic          raddr_ok;
  logic          wr_en;
  logic          rd_en;
  logic [M-1:0]  lane_mask;
  logic [M-1:0]  old_word;
  logic [M-1:0]  rd_word_d;

  logic          rvld1_q;
  logic [M-1:0]  rdata1_q;

  // ---------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == LAST) begin
          state_d   = READY;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + AW'(1);
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign busy = (state_q == CLEAR);

  // ---------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------
  // Addresses at or above N exist only for non-power-of-two depths; writes
  // there are dropped and reads return zero.
  assign waddr_ok = ({1'b0, waddr} < DEPTH);
  assign raddr_ok = ({1'b0, raddr} < DEPTH);

  // The edge on which the clear finishes still sees state CLEAR, so a
  // request coinciding with busy falling is ignored as well.
  assign wr_en = (state_q == READY) && we && waddr_ok;
  assign rd_en = (state_q == READY) && re;

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < NB; i++) begin
      lane_mask[8*i +: 8] = {8{wbe[i]}};
    end
  end

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem[clr_cnt_q] <= '0;
      end else if (wr_en) begin
        for (int i = 0; i < NB; i++) begin
          if (wbe[i]) begin
            mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  // The array read sees pre-write contents; in write-first mode a same-address
  // collision is patched lane by lane with the incoming write data.
  always_comb begin
    old_word  = raddr_ok ? mem[raddr] : '0;
    rd_word_d = old_word;
    if ((WRITE_FIRST != 0) && wr_en && (waddr == raddr)) begin
      rd_word_d = (old_word & ~lane_mask) | (wdata & lane_mask);
    end
  end

  // First output stage: rdata only moves on a real result so it holds
  // between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvld1_q  <= 1'b0;
      rdata1_q <= '0;
    end else begin
      rvld1_q <= rd_en;
      if (rd_en) begin
        rdata1_q <= rd_word_d;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic          rvld2_q;
      logic [M-1:0]  rdata2_q;

      // Extra register stage; reset drops anything still in stage one.
      always_ff @(posedge clk) begin
        if (rst) begin
          rvld2_q  <= 1'b0;
          rdata2_q <= '0;
        end else begin
          rvld2_q <= rvld1_q;
          if (rvld1_q) begin
            rdata2_q <= rdata1_q;
          end
        end
      end

      assign rvalid = rvld2_q;
      assign rdata  = rdata2_q;
    end else begin : g_lat1
      assign rvalid = rvld1_q;
      assign rdata  = rdata1_q;
    end
  endgenerate

endmodule

// File: tb/tb_sram_sdp_be.sv
// tb_sram_sdp_be: drives three memory variants (write-first/1-cycle,
//   read-first/1-cycle, write-first/2-cycle) with one shared stimulus
//   stream and compares every output against an array-based reference.

module tb_sram_sdp_be;

  localparam int M = 16;
  localparam int N = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  wbe = '0;
  logic        re = 1'b0;
  logic [3:0]  raddr = '0;

  logic [15:0] rdata_a, rdata_b, rdata_c;
  logic        rvalid_a, rvalid_b, rvalid_c;
  logic        busy_a, busy_b, busy_c;

  always #5 clk = ~clk;

  sram_sdp_be #(.M(M), .N(N), .RD_LAT(1), .WRITE_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a), .busy(busy_a)
  );

  sram_sdp_be #(.M(M), .N(N), .RD_LAT(1), .WRITE_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b), .busy(busy_b)
  );

  sram_sdp_be #(.M(M), .N(N), .RD_LAT(2), .WRITE_FIRST(1)) dut_c (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(rdata_c), .rvalid(rvalid_c), .busy(busy_c)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] ref_mem [N];
  int          clr_left = 0;
  bit          known = 1'b0;
  logic        pend_v = 1'b0;
  logic [15:0] pend_d = '0;
  logic        exp_rv_a = 1'b0, exp_rv_b = 1'b0, exp_rv_c = 1'b0;
  logic [15:0] exp_rd_a = '0, exp_rd_b = '0, exp_rd_c = '0;
  logic        exp_busy = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Applies the inputs present at one rising edge to the reference.
  task automatic model_edge();
    logic [15:0] mask;
    logic [15:0] old_w;
    logic [15:0] new_w;
    logic        fire;
    fire  = 1'b0;
    old_w = '0;
    new_w = '0;
    if (rst) begin
      known    = 1'b1;
      clr_left = N;
      pend_v   = 1'b0;
      exp_rv_a = 1'b0; exp_rv_b = 1'b0; exp_rv_c = 1'b0;
      exp_rd_a = '0;   exp_rd_b = '0;   exp_rd_c = '0;
      exp_busy = 1'b1;
      return;
    end
    if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0) begin
        for (int i = 0; i < N; i++) ref_mem[i] = '0;
      end
    end else begin
      mask = {{8{wbe[1]}}, {8{wbe[0]}}};
      if (re) begin
        fire  = 1'b1;
        old_w = (raddr < N) ? ref_mem[raddr] : 16'h0000;
        new_w = old_w;
        if (we && (waddr == raddr) && (raddr < N)) new_w = (old_w & ~mask) | (wdata & mask);
      end
      if (we && (waddr < N)) ref_mem[waddr] = (ref_mem[waddr] & ~mask) | (wdata & mask);
    end
    exp_rv_a = fire;
    if (fire) exp_rd_a = new_w;
    exp_rv_b = fire;
    if (fire) exp_rd_b = old_w;
    exp_rv_c = pend_v;
    if (pend_v) exp_rd_c = pend_d;
    pend_v   = fire;
    pend_d   = new_w;
    exp_busy = (clr_left > 0);
  endtask

  // One clock: edge, model update, then sample outputs 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    if (known) begin
      chk("busy_a", 32'(busy_a), 32'(exp_busy));
      chk("busy_b", 32'(busy_b), 32'(exp_busy));
      chk("busy_c", 32'(busy_c), 32'(exp_busy));
      chk("rvalid_a", 32'(rvalid_a), 32'(exp_rv_a));
      chk("rvalid_b", 32'(rvalid_b), 32'(exp_rv_b));
      chk("rvalid_c", 32'(rvalid_c), 32'(exp_rv_c));
      chk("rdata_a", 32'(rdata_a), 32'(exp_rd_a));
      chk("rdata_b", 32'(rdata_b), 32'(exp_rd_b));
      chk("rdata_c", 32'(rdata_c), 32'(exp_rd_c));
    end
  endtask

  // Counts visible busy cycles from the current point, bounded at 20.
  task automatic busy_len(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy_a) break;
      n++;
      cyc();
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    we = 1'b1; waddr = a; wdata = d; wbe = be; re = 1'b0;
    cyc();
    we = 1'b0;
  endtask

  initial begin
    int n;
    logic [15:0] got [$];

    // ---- reset then clear, with reads requested while busy ----
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0; re = 1'b1; raddr = 4'd0;
    busy_len(n);
    chk("clear_len", 32'(n), 32'd12);

    n = 0;
    for (int i = 0; i < N; i++) begin
      raddr = 4'(i);
      cyc();
      if (rvalid_a) n++;
      chk("clear_zero", 32'(rdata_a), 32'h0);
    end
    re = 1'b0;
    chk("clear_rvalid_run", 32'(n), 32'd12);
    cyc();

    // ---- byte-enable write ----
    do_write(4'd3, 16'hA1B2, 2'b11);
    do_write(4'd3, 16'hFFC4, 2'b01);
    re = 1'b1; raddr = 4'd3;
    cyc();
    re = 1'b0;
    chk("be_merge_data", 32'(rdata_a), 32'hA1C4);
    chk("be_merge_valid", 32'(rvalid_a), 32'd1);

    // ---- same-address collision ----
    do_write(4'd5, 16'h1234, 2'b11);
    we = 1'b1; waddr = 4'd5; wdata = 16'hABCD; wbe = 2'b10;
    re = 1'b1; raddr = 4'd5;
    cyc();
    we = 1'b0;
    chk("coll_write_first", 32'(rdata_a), 32'hAB34);
    chk("coll_read_first", 32'(rdata_b), 32'h1234);
    cyc();
    re = 1'b0;
    chk("coll_after_read", 32'(rdata_b), 32'hAB34);
    chk("coll_lat2", 32'(rdata_c), 32'hAB34);
    cyc();

    // ---- two-cycle latency streaming ----
    for (int i = 0; i < 4; i++) do_write(4'(i), 16'h0010 + 16'(i), 2'b11);
    re = 1'b1; raddr = 4'd0;
    cyc();
    chk("lat2_gap", 32'(rvalid_c), 32'd0);
    for (int i = 1; i < 6; i++) begin
      re = (i < 4); raddr = 4'(i);
      cyc();
      if (rvalid_c) got.push_back(rdata_c);
    end
    re = 1'b0;
    chk("lat2_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size() && i < 4; i++) begin
      chk("lat2_order", 32'(got[i]), 32'h0010 + 32'(i));
    end

    // ---- out-of-range ----
    do_write(4'd13, 16'h5555, 2'b11);
    re = 1'b1; raddr = 4'd13;
    cyc();
    re = 1'b0;
    chk("oor_data", 32'(rdata_a), 32'h0);
    chk("oor_valid", 32'(rvalid_a), 32'd1);
    cyc();

    // ---- reset with a read in flight, then reset mid-clear ----
    do_write(4'd7, 16'hBEEF, 2'b11);
    re = 1'b1; raddr = 4'd7;
    cyc();
    re = 1'b0; rst = 1'b1;
    cyc();
    chk("inflight_drop", 32'(rvalid_c), 32'd0);
    rst = 1'b0; re = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    busy_len(n);
    chk("reclear_len", 32'(n), 32'd12);
    raddr = 4'd7;
    cyc();
    re = 1'b0;
    chk("reclear_data", 32'(rdata_a), 32'h0);
    chk("reclear_valid", 32'(rvalid_a), 32'd1);
    cyc();

    // ---- randomized traffic with occasional resets ----
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(99, 0) == 0);
      we    = 1'($urandom_range(1, 0));
      waddr = 4'($urandom_range(13, 0));
      wdata = 16'($urandom);
      wbe   = 2'($urandom_range(3, 0));
      re    = 1'($urandom_range(1, 0));
      raddr = ($urandom_range(3, 0) == 0) ? waddr : 4'($urandom_range(13, 0));
      cyc();
    end
    rst = 1'b0; we = 1'b0; re = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_sdp_be.md
# sram_sdp_be

Parametrised simple-dual-port synchronous SRAM: one write port with byte-lane enables, one registered read port with valid strobe, selectable read latency and read-during-write policy. Supports non-power-of-two depth and hardware clear-on-reset. Next-generation replacement for the single-port async-read memory, for buffers and lookup tables that need sync read, byte writes and known contents after reset.

## Interface
- `M`, default 8: data width in bits; must be a multiple of 8.
- `N`, default 1024: depth in words; any value ≥ 2, need not be a power of two.
- `RD_LAT`, default 1: read latency in cycles; legal values 1 or 2.
- `WRITE_FIRST`, default 1: same-address read-during-write policy; 1 = new data, 0 = old data.
- `AW`, derived: address width, `$clog2(N)`.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `we` in 1: write request.
- `waddr` in AW: write address.
- `wdata` in M: write data.
- `wbe` in M/8: byte-lane enables; bit i covers `wdata[8i+7:8i]`.
- `re` in 1: read request.
- `raddr` in AW: read address.
- `rdata` out M: read data.
- `rvalid` out 1: one-cycle strobe marking `rdata` as the result of a read.
- `busy` out 1: clear sequence in progress; requests ignored.

## Operation
- FSM states: CLEAR, READY.
- `rst` high at an edge: state becomes CLEAR, clear counter becomes 0, read pipeline flushed.
  - Outputs after that edge: `busy`=1, `rvalid`=0, `rdata`=0.
- CLEAR:
  - Each edge with `rst` low writes all-zero to `mem[counter]` and increments the counter.
  - After the edge that writes address N-1, state becomes READY and `busy`=0.
  - Clear therefore takes exactly N cycles after `rst` falls.
  - `we` and `re` are ignored: no write, no `rvalid`.
- Reset during CLEAR or with reads in flight: restarts CLEAR from address 0. In-flight reads are dropped and never produce `rvalid`.
- Write (READY, `we`=1): for each lane i with `wbe[i]`=1, that byte of `mem[waddr]` takes the `wdata` byte. Other lanes are unchanged. `wbe`=0 is a legal no-op.
- Read (READY, `re`=1): `raddr` is sampled and the word returned after `RD_LAT` edges.
- Independent ports: a read and a write may both occur at the same edge, at any addresses.
- Same-address collision (`re`, `we`, `raddr`==`waddr` at the same edge):
  - `WRITE_FIRST`=1: returned word is per-lane merged — lanes with `wbe` set carry `wdata`, the rest carry old contents.
  - `WRITE_FIRST`=0: returned word is the full pre-write contents.
- Out-of-range address (≥ N, possible only when N is not a power of two):
  - Write is discarded.
  - Read returns 0 with `rvalid`=1.
- `rdata` holds its last value while `rvalid`=0. It changes only on a valid-result edge or on reset.

## Timing
- `RD_LAT`=1: `re` sampled at edge k → `rdata`/`rvalid` updated at edge k. Visible during cycle k+1; `rvalid` high for one cycle.
- `RD_LAT`=2: one additional output register stage. Result visible during cycle k+2.
- Throughput: one read and one write per cycle, back-to-back, no stalls.
- Write latency: a write at edge k is visible to a read sampled at edge k+1 under both policies. At edge k itself, the collision rule above applies.
- `busy` falls at the N-th edge after `rst` falls. A request sampled on that same edge is still ignored. The first accepted request is at edge N+1.
- No combinational path from any input to any output.

## Test plan
Bench parameters: M=16, N=12, RD_LAT=1, WRITE_FIRST=1 unless noted.

- Reset then clear:
  - Drive `rst` high for 2 cycles, release.
  - Required: `busy` stays 1 for exactly 12 cycles.
  - Then read addresses 0..11 back-to-back: every `rdata`=0x0000, `rvalid` high on 12 consecutive cycles.
- Byte-enable write:
  - Write 0xA1B2 with `wbe`=11 to address 3, then 0xFFC4 with `wbe`=01 to address 3.
  - Read address 3: `rdata`=0xA1C4, one cycle after `re`.
- Collision, WRITE_FIRST=1:
  - Address 5 holds 0x1234.
  - Same edge: write 0xABCD `wbe`=10 to 5, read 5.
  - Required: `rdata`=0xAB34.
  - Rerun with WRITE_FIRST=0: `rdata`=0x1234; a subsequent read returns 0xAB34.
- RD_LAT=2 streaming:
  - Fill addresses 0..3 with 0x0010..0x0013.
  - Issue reads 0,1,2,3 on consecutive cycles.
  - Required: `rvalid` high on cycles k+2..k+5 with data 0x0010..0x0013 in order.
- Out of range and busy masking:
  - Write 0x5555 to address 13, then read address 13: `rdata`=0x0000 with `rvalid`=1.
  - `re`=1 while `busy`=1: `rvalid` stays 0.
- Reset mid-clear and mid-read:
  - Assert `rst` 5 cycles into CLEAR while a read is in flight.
  - Required: no `rvalid`; after release `busy` lasts the full 12 cycles; a word written before reset reads back as 0.
